// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encoding and default frame parameters.
// Exports: rx_state_t, UART_DATA_BITS, UART_OVERSAMPLE, UART_SYNC_STAGES.
// Used by the receiver top, its controller and its handshake interface.
package uart_pkg;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  localparam int UART_DATA_BITS   = 8;
  localparam int UART_OVERSAMPLE  = 16;
  localparam int UART_SYNC_STAGES = 2;

endpackage

// File: rtl/uart_rx_if.sv
// Byte handshake from the UART receiver to its consumer, plus error pulses.
// master (receiver): drives rx_data, valid_out, frame_err, overrun_err; reads ready_in.
// slave (consumer): the mirror image.
interface uart_rx_if
  import uart_pkg::*;
#(
  parameter int DATA_BITS = UART_DATA_BITS
);

  logic [DATA_BITS-1:0] rx_data;
  logic                 valid_out;
  logic                 ready_in;
  logic                 frame_err;
  logic                 overrun_err;

  modport master (
    output rx_data,
    output valid_out,
    output frame_err,
    output overrun_err,
    input  ready_in
  );

  modport slave (
    input  rx_data,
    input  valid_out,
    input  frame_err,
    input  overrun_err,
    output ready_in
  );

endinterface

// File: rtl/uart_rx_controller.sv
// UART receive FSM: start validation, data bit sequencing, stop bit check.
// Inputs: clk, reset (async active-low), baud_en, rx_s, counter terminal flags.
// Outputs: single-cycle strobes sample_en/shift_en/frame_done/frame_err, os_clr, registered busy.
module uart_rx_controller
  import uart_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic baud_en,
  input  logic rx_s,
  input  logic os_mid,
  input  logic os_last,
  input  logic bit_last,
  output logic sample_en,
  output logic shift_en,
  output logic frame_done,
  output logic frame_err,
  output logic os_clr,
  output logic busy
);

  rx_state_t state_q;
  logic      stop_smp;

  // Strobes are decoded from the current state so the datapath acts on the
  // same edge the FSM moves; this keeps stop-sample -> valid_out at one clock.
  assign os_clr     = (state_q == RX_IDLE);
  assign sample_en  = baud_en & os_mid  & (state_q == RX_START);
  assign shift_en   = baud_en & os_last & (state_q == RX_DATA);
  assign stop_smp   = baud_en & os_last & (state_q == RX_STOP);
  assign frame_done = stop_smp & rx_s;
  assign frame_err  = stop_smp & ~rx_s;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RX_IDLE;
      busy    <= 1'b0;
    end else begin
      case (state_q)
        RX_IDLE: begin
          if (!rx_s) begin
            state_q <= RX_START;
            busy    <= 1'b1;
          end
        end
        RX_START: begin
          if (sample_en) begin
            // A start bit that is high again at mid-bit was a glitch.
            if (rx_s) begin
              state_q <= RX_IDLE;
              busy    <= 1'b0;
            end else begin
              state_q <= RX_DATA;
            end
          end
        end
        RX_DATA: begin
          if (shift_en && bit_last) begin
            state_q <= RX_STOP;
          end
        end
        RX_STOP: begin
          // Leave at mid stop bit; the second half is slack for the next start.
          if (stop_smp) begin
            state_q <= RX_IDLE;
            busy    <= 1'b0;
          end
        end
        default: begin
          state_q <= RX_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronises rx, oversamples on baud_en, delivers bytes over a one-entry valid/ready buffer.
// Ports: clk, reset (async active-low), baud_en, rx, busy; rx_if.master carries rx_data/valid_out/ready_in/frame_err/overrun_err.
// Stop-sample edge -> valid_out in 1 clk; a byte completing into a full, unconsumed buffer is dropped with overrun_err.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = UART_DATA_BITS,
  parameter int OVERSAMPLE  = UART_OVERSAMPLE,
  parameter int SYNC_STAGES = UART_SYNC_STAGES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       baud_en,
  input  logic       rx,
  output logic       busy,
  uart_rx_if.master  rx_if
);

  localparam int OS_W = $clog2(OVERSAMPLE);
  localparam int BC_W = $clog2(DATA_BITS + 1);

  localparam logic [OS_W-1:0] OS_MID  = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_BITS - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [OS_W-1:0]        os_cnt_q, os_cnt_d;
  logic [BC_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   frame_err_q, frame_err_d;
  logic                   overrun_q, overrun_d;

  logic rx_s;
  logic sample_en, shift_en, frame_done, frame_err_stb, os_clr;
  logic load;

  assign rx_s = sync_q[SYNC_STAGES-1];

  uart_rx_controller u_ctrl (
    .clk        (clk),
    .reset      (reset),
    .baud_en    (baud_en),
    .rx_s       (rx_s),
    .os_mid     (os_cnt_q == OS_MID),
    .os_last    (os_cnt_q == OS_LAST),
    .bit_last   (bit_cnt_q == BC_LAST),
    .sample_en  (sample_en),
    .shift_en   (shift_en),
    .frame_done (frame_done),
    .frame_err  (frame_err_stb),
    .os_clr     (os_clr),
    .busy       (busy)
  );

  // A completed byte may load when the buffer is empty or is being drained
  // on this very cycle, so a back-to-back consumer never sees a gap or overrun.
  assign load = frame_done & (~valid_q | rx_if.ready_in);

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], rx};

    // Held at zero in IDLE and restarted at the start-bit sample so data
    // samples fall a whole bit period after mid-start.
    os_cnt_d = os_cnt_q;
    if (os_clr || sample_en) begin
      os_cnt_d = '0;
    end else if (baud_en) begin
      os_cnt_d = (os_cnt_q == OS_LAST) ? '0 : os_cnt_q + OS_W'(1);
    end

    bit_cnt_d = bit_cnt_q;
    if (sample_en) begin
      bit_cnt_d = '0;
    end else if (shift_en) begin
      bit_cnt_d = bit_cnt_q + BC_W'(1);
    end

    // LSB arrives first: shifting right leaves it at bit 0 after the last bit.
    shift_d = shift_q;
    if (shift_en) begin
      shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
    end

    data_d  = load ? shift_q : data_q;
    valid_d = valid_q;
    if (load) begin
      valid_d = 1'b1;
    end else if (valid_q && rx_if.ready_in) begin
      valid_d = 1'b0;
    end

    frame_err_d = frame_err_stb;
    overrun_d   = frame_done & valid_q & ~rx_if.ready_in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q      <= '1;
      os_cnt_q    <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      os_cnt_q    <= os_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx_if.rx_data     = data_q;
  assign rx_if.valid_out   = valid_q;
  assign rx_if.frame_err   = frame_err_q;
  assign rx_if.overrun_err = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: OVERSAMPLE=16 with baud_en every 4 clocks (64 clocks per bit).
// A negedge monitor counts handshakes, valid cycles and error pulses; steps compare deltas.
// ready_in changes 1 ns after a rising edge so the monitor never races it.
module tb_uart_rx;

  logic clk;
  logic reset;
  logic baud_en;
  logic rx;
  logic busy;

  uart_rx_if #(.DATA_BITS(8)) rx_if ();

  uart_rx dut (
    .clk     (clk),
    .reset   (reset),
    .baud_en (baud_en),
    .rx      (rx),
    .busy    (busy),
    .rx_if   (rx_if)
  );

  int n_assert = 0;
  int n_fail   = 0;

  int       hs_cnt = 0, vc_cnt = 0, fe_cnt = 0, ov_cnt = 0;
  logic [7:0] last_hs = '0;
  int       hs0, vc0, fe0, ov0;
  int       bcnt;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    baud_en = 1'b0;
    bcnt    = 0;
    forever begin
      @(negedge clk);
      bcnt    = (bcnt + 1) % 4;
      baud_en = (bcnt == 0);
    end
  end

  always @(negedge clk) begin
    if (rx_if.valid_out) vc_cnt <= vc_cnt + 1;
    if (rx_if.valid_out && rx_if.ready_in) begin
      hs_cnt  <= hs_cnt + 1;
      last_hs <= rx_if.rx_data;
    end
    if (rx_if.frame_err)   fe_cnt <= fe_cnt + 1;
    if (rx_if.overrun_err) ov_cnt <= ov_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    hs0 = hs_cnt; vc0 = vc_cnt; fe0 = fe_cnt; ov0 = ov_cnt;
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 rx_if.ready_in = v;
  endtask

  // Called at a falling edge; one start bit, 8 data bits LSB first, one stop bit.
  // A low stop bit is held only past its mid-bit sample point.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    rx = 1'b0;
    repeat (64) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (64) @(negedge clk);
    end
    rx = stop_bit;
    repeat (stop_bit ? 64 : 48) @(negedge clk);
    rx = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    rx    = 1'b1;
    rx_if.ready_in = 1'b1;
    #1;
    check("reset_rx_data",     32'(rx_if.rx_data),     32'h0);
    check("reset_valid_out",   32'(rx_if.valid_out),   32'h0);
    check("reset_frame_err",   32'(rx_if.frame_err),   32'h0);
    check("reset_overrun_err", 32'(rx_if.overrun_err), 32'h0);
    check("reset_busy",        32'(busy),              32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);

    // 1: clean 0xA5, consumer always ready
    snap();
    send_frame(8'hA5, 1'b1);
    repeat (20) @(negedge clk);
    check("t1_handshakes",  32'(hs_cnt - hs0), 32'd1);
    check("t1_data",        32'(last_hs),      32'hA5);
    check("t1_valid_cycles",32'(vc_cnt - vc0), 32'd1);
    check("t1_frame_err",   32'(fe_cnt - fe0), 32'd0);
    check("t1_overrun",     32'(ov_cnt - ov0), 32'd0);

    // 2: 6-tick low glitch is rejected at the mid-start sample
    snap();
    rx = 1'b0;
    repeat (10) @(negedge clk);
    check("t2_busy_in_start", 32'(busy), 32'd1);
    repeat (14) @(negedge clk);
    rx = 1'b1;
    repeat (100) @(negedge clk);
    check("t2_busy_idle",    32'(busy),         32'd0);
    check("t2_valid_cycles", 32'(vc_cnt - vc0), 32'd0);
    check("t2_frame_err",    32'(fe_cnt - fe0), 32'd0);

    // 3: 0x3C with a low stop bit
    snap();
    send_frame(8'h3C, 1'b0);
    repeat (100) @(negedge clk);
    check("t3_frame_err",    32'(fe_cnt - fe0), 32'd1);
    check("t3_valid_cycles", 32'(vc_cnt - vc0), 32'd0);
    check("t3_busy_idle",    32'(busy),         32'd0);

    // 4: 0x11 then 0x22 back-to-back with consumer stalled
    set_ready(1'b0);
    @(negedge clk);
    snap();
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    repeat (20) @(negedge clk);
    check("t4_valid_held", 32'(rx_if.valid_out), 32'd1);
    check("t4_data_held",  32'(rx_if.rx_data),   32'h11);
    check("t4_overrun",    32'(ov_cnt - ov0),    32'd1);
    check("t4_no_hs",      32'(hs_cnt - hs0),    32'd0);
    set_ready(1'b1);
    repeat (4) @(negedge clk);
    check("t4_consumed_hs",   32'(hs_cnt - hs0),    32'd1);
    check("t4_consumed_data", 32'(last_hs),         32'h11);
    check("t4_valid_cleared", 32'(rx_if.valid_out), 32'd0);

    // 5: reset in the middle of data bit 4 of 0xFF, then a clean 0x5A
    snap();
    rx = 1'b0;
    repeat (64) @(negedge clk);
    rx = 1'b1;
    repeat (4 * 64 + 32) @(negedge clk);
    check("t5_busy_mid_frame", 32'(busy), 32'd1);
    reset = 1'b0;
    #2;
    check("t5_rst_rx_data",     32'(rx_if.rx_data),     32'h0);
    check("t5_rst_valid_out",   32'(rx_if.valid_out),   32'h0);
    check("t5_rst_frame_err",   32'(rx_if.frame_err),   32'h0);
    check("t5_rst_overrun_err", 32'(rx_if.overrun_err), 32'h0);
    check("t5_rst_busy",        32'(busy),              32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (700) @(negedge clk);
    check("t5_abandoned_busy", 32'(busy),         32'd0);
    check("t5_abandoned_hs",   32'(hs_cnt - hs0), 32'd0);
    check("t5_abandoned_fe",   32'(fe_cnt - fe0), 32'd0);
    snap();
    send_frame(8'h5A, 1'b1);
    repeat (20) @(negedge clk);
    check("t5_hs",   32'(hs_cnt - hs0), 32'd1);
    check("t5_data", 32'(last_hs),      32'h5A);

    // 6: buffer holds 0x01; ready_in rises exactly on the 0x02 load cycle.
    // Frame starts at a falling edge right after a baud_en edge: the stop
    // sample lands on the 608th rising edge after rx falls.
    set_ready(1'b0);
    @(negedge clk);
    send_frame(8'h01, 1'b1);
    repeat (20) @(negedge clk);
    check("t6_held_valid", 32'(rx_if.valid_out), 32'd1);
    check("t6_held_data",  32'(rx_if.rx_data),   32'h01);
    snap();
    do @(posedge clk); while (baud_en !== 1'b1);
    @(negedge clk);
    fork
      send_frame(8'h02, 1'b1);
      begin
        repeat (606) @(negedge clk);
        @(posedge clk);
        #1 rx_if.ready_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t6_load_valid", 32'(rx_if.valid_out), 32'd1);
        check("t6_load_data",  32'(rx_if.rx_data),   32'h02);
      end
    join
    repeat (20) @(negedge clk);
    check("t6_overrun",  32'(ov_cnt - ov0),    32'd0);
    check("t6_hs",       32'(hs_cnt - hs0),    32'd2);
    check("t6_last",     32'(last_hs),         32'h02);
    check("t6_drained",  32'(rx_if.valid_out), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
